regfile_wb_arbiter: RTL

- Shares the register file's single write port between two writers:
  - the core writeback path, which is single-cycle and has priority;
  - a long-latency unit (load/mul/div) with a valid/ready handshake.
- Long-latency results are buffered in a small FIFO.
- A starvation guard briefly stalls the core so buffered results always drain.
- A 32-entry busy scoreboard tracks registers awaiting long-latency results and answers rs1/rs2 hazard queries for the decode stage.

---
 rtl/regfile_wb_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: core writeback has priority, buffered long-latency results drain via starvation guard; busy scoreboard answers decode hazards.
// Latency: core write same cycle; long-latency result reaches the write port >=1 cycle after acceptance. Backpressure: lu_ready drops when the FIFO is full, core_stall on a forced drain.

module regfile_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] dat_i,
    input  logic         pop_i,
    output logic [W-1:0] dat_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;

    assign dat_o   = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= dat_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_i && !pop_i) begin
                cnt_q <= cnt_q + (AW+1)'(1);
            end else if (pop_i && !push_i) begin
                cnt_q <= cnt_q - (AW+1)'(1);
            end
        end
    end
endmodule

module regfile_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_we,
    input  logic [4:0]  core_rd,
    input  logic [31:0] core_wdata,
    output logic        core_stall,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_wdata,
    output logic        lu_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        err_waw,
    output logic        rf_regWrite,
    output logic [4:0]  rf_writeReg,
    output logic [31:0] rf_writeData
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] dat;
    } wb_t;

    wb_t           head, lu_entry;
    logic          fifo_empty, fifo_full, push, sec_grant, core_win;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]   busy_q, busy_d;
    logic          err_waw_q, err_waw_d;

    assign lu_entry = '{rd: lu_rd, dat: lu_wdata};
    assign lu_ready = !reset && !fifo_full;
    assign push     = lu_valid && lu_ready;

    regfile_wb_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(wb_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .dat_i   (lu_entry),
        .pop_i   (sec_grant),
        .dat_o   (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // The buffered result wins when the core is idle or has already won STARVE_LIMIT times in a row.
    assign sec_grant  = !reset && !fifo_empty && (!core_we || wait_cnt_q == LIMIT);
    assign core_win   = !reset && core_we && !sec_grant;
    assign core_stall = !reset && core_we && sec_grant;

    assign issue_ready = !reset && issue_valid && (issue_rd != 5'd0) && !busy_q[issue_rd];
    assign rs1_busy    = !reset && busy_q[rs1];
    assign rs2_busy    = !reset && busy_q[rs2];
    assign err_waw     = !reset && err_waw_q;

    always_comb begin
        rf_regWrite  = 1'b0;
        rf_writeReg  = 5'd0;
        rf_writeData = 32'd0;
        if (sec_grant) begin
            rf_regWrite  = (head.rd != 5'd0);
            rf_writeReg  = head.rd;
            rf_writeData = head.dat;
        end else if (core_win) begin
            rf_regWrite  = (core_rd != 5'd0);
            rf_writeReg  = core_rd;
            rf_writeData = core_wdata;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (fifo_empty || sec_grant) begin
            wait_cnt_d = '0;
        end else if (core_win && wait_cnt_q != LIMIT) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
    end

    // Clear is applied after set so a same-cycle commit of the issued register leaves it free.
    always_comb begin
        busy_d = busy_q;
        if (issue_ready) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (sec_grant) begin
            busy_d[head.rd] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    assign err_waw_d = err_waw_q || (core_win && core_rd != 5'd0 && busy_q[core_rd]);

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            busy_q     <= '0;
            err_waw_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            busy_q     <= busy_d;
            err_waw_q  <= err_waw_d;
        end
    end
endmodule
